multicycle_ctrl: RTL and testbench

- Main sequencing FSM for the multicycle variant of the RV32I core. One shared memory port serves fetch and load/store. The FSM sequences IR/PC capture, operand selection, ALU operation, memory access and register writeback over 3–5 cycles per instruction.
- Supported instructions: lw, sw, R-type and I-type ALU ops (add/sub/slt/or/and), beq, bne, jal.
- A variable-latency memory handshake and a stall watchdog make it suitable for slow or shared memory.

---
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and its datapath/memory.
interface multicycle_ctrl_if;
  // Instruction fields and datapath/memory status
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  // Strobes and selects
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemReq;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  // Sticky status and debug
  logic       illegal;
  logic       bus_err;
  logic [3:0] state_o;

  // Sequencer side
  modport master (
    input  op, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    output illegal, bus_err, state_o
  );

  // Datapath/memory side
  modport slave (
    output op, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
    input  illegal, bus_err, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle RV32I core, with a shared-memory stall watchdog.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StHalt     = 4'd15
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam bit WdEnable = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] WdLast =
    CNT_WIDTH'(WdEnable ? TIMEOUT_CYCLES - 1 : 0);

  state_e               r_state, w_state_d;
  logic                 r_illegal, w_illegal_d;
  logic                 r_bus_err, w_bus_err_d;
  logic [CNT_WIDTH-1:0] r_wd_cnt, w_wd_cnt_d;

  logic       w_mem_phase, w_stall, w_timeout;
  logic       w_alu_ok, w_br_ok;
  logic [2:0] w_alu_op;

  logic       w_pc_write, w_adr_src, w_mem_req, w_mem_write, w_ir_write, w_reg_write;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_imm_src;
  logic [2:0] w_alu_control;

  // MemReq depends on state only, so the watchdog can see it without a comb loop
  assign w_mem_phase = r_state inside {StFetch, StMemRead, StMemWrite};
  assign w_stall     = w_mem_phase & ~bus.mem_ready;
  assign w_timeout   = WdEnable && w_stall && (r_wd_cnt == WdLast);
  assign w_br_ok     = (bus.funct3[2:1] == 2'b00);

  // ALU operation and legality for the R/I-type funct3 field
  always_comb begin
    w_alu_ok = 1'b1;
    w_alu_op = 3'b000;
    case (bus.funct3)
      3'b000:  w_alu_op = (bus.op == OpRType && bus.funct7_5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_op = 3'b101;
      3'b110:  w_alu_op = 3'b011;
      3'b111:  w_alu_op = 3'b010;
      default: w_alu_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Sticky error flags and watchdog counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_wd_cnt  <= '0;
    end else begin
      r_illegal <= w_illegal_d;
      r_bus_err <= w_bus_err_d;
      r_wd_cnt  <= w_wd_cnt_d;
    end
  end

  // Next-state, error flags and watchdog next value
  always_comb begin
    w_state_d   = r_state;
    w_illegal_d = r_illegal;
    w_bus_err_d = r_bus_err;
    case (r_state)
      StFetch:    if (bus.mem_ready) w_state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: w_state_d = StMemAdr;
          OpRType:         w_state_d = w_alu_ok ? StExecR : StHalt;
          OpIType:         w_state_d = w_alu_ok ? StExecI : StHalt;
          OpBranch:        w_state_d = w_br_ok ? StBranch : StHalt;
          OpJal:           w_state_d = StJal;
          default:         w_state_d = StHalt;
        endcase
        if (w_state_d == StHalt) w_illegal_d = 1'b1;
      end
      StMemAdr:   w_state_d = (bus.op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (bus.mem_ready) w_state_d = StMemWb;
      StMemWb:    w_state_d = StFetch;
      StMemWrite: if (bus.mem_ready) w_state_d = StFetch;
      StExecR,
      StExecI:    w_state_d = StAluWb;
      StAluWb,
      StBranch:   w_state_d = StFetch;
      StJal:      w_state_d = StAluWb;
      StHalt:     w_state_d = StHalt;
      default:    w_state_d = StHalt;
    endcase
    // A transfer completing on the last allowed cycle wins, since w_timeout needs a stall
    if (w_timeout) begin
      w_state_d   = StHalt;
      w_bus_err_d = 1'b1;
    end
    if (!WdEnable || !w_stall || (w_state_d != r_state)) begin
      w_wd_cnt_d = '0;
    end else begin
      w_wd_cnt_d = r_wd_cnt + 1'b1;
    end
  end

  // Moore outputs with mem_ready gating in FETCH; strobes forced low while in reset
  always_comb begin
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_imm_src     = 2'b00;
    w_alu_control = 3'b000;
    case (r_state)
      StFetch: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_alu_src_b  = 2'b10;
          w_result_src = 2'b10;
        end
      end
      StDecode: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          OpStore:  w_imm_src = 2'b01;
          OpBranch: w_imm_src = 2'b10;
          OpJal:    w_imm_src = 2'b11;
          default:  w_imm_src = 2'b00;
        endcase
      end
      StMemAdr: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = (bus.op == OpStore) ? 2'b01 : 2'b00;
      end
      StMemRead: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      StMemWb: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      StMemWrite: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
      end
      StExecR: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = w_alu_op;
      end
      StExecI: begin
        w_alu_src_a   = 2'b10;
        w_alu_src_b   = 2'b01;
        w_alu_control = w_alu_op;
      end
      StAluWb:    w_reg_write = 1'b1;
      StBranch: begin
        w_alu_src_a   = 2'b10;
        w_alu_control = 3'b001;
        // Only beq/bne reach this state, so funct3[0] selects the polarity
        w_pc_write    = bus.funct3[0] ? ~bus.Zero : bus.Zero;
      end
      StJal: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      w_pc_write  = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
    end
  end

  assign bus.PCWrite    = w_pc_write;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.MemReq     = w_mem_req;
  assign bus.MemWrite   = w_mem_write;
  assign bus.IRWrite    = w_ir_write;
  assign bus.RegWrite   = w_reg_write;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ALUControl = w_alu_control;
  assign bus.illegal    = r_illegal;
  assign bus.bus_err    = r_bus_err;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction streams checked against a per-instruction phase model.
module tb_multicycle_ctrl;
  localparam int Timeout = 16;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBr  = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;

  // Phase numbers as they appear on state_o
  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRead = 3, SMemWb = 4;
  localparam int SMemWrite = 5, SExecR = 6, SExecI = 7, SAluWb = 8, SBranch = 9;
  localparam int SJal = 10, SHalt = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int st;
    bit rdy;
  } step_t;
  step_t seq[$];

  multicycle_ctrl_if bus();

  multicycle_ctrl #(
    .TIMEOUT_CYCLES(Timeout),
    .CNT_WIDTH     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] strobes_now();
    return {bus.PCWrite, bus.AdrSrc, bus.MemReq, bus.MemWrite, bus.IRWrite, bus.RegWrite};
  endfunction

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OpLw, OpSw, OpJal: return 1'b1;
      OpR, OpI:          return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
      OpBr:              return f3 < 3'd2;
      default:           return 1'b0;
    endcase
  endfunction

  // add/sub, slt, or, and encoded as the ALU expects
  function automatic int alu_code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (op == OpR && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  // Which strobes fire in a phase: {PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, RegWrite}
  function automatic logic [5:0] exp_strobes(input int st, input bit rdy,
                                             input logic [2:0] f3, input logic zero);
    bit taken;
    taken = (f3 == 3'd0) ? zero : !zero;
    return {(st == SFetch && rdy) || st == SJal || (st == SBranch && taken),
            st == SMemRead || st == SMemWrite,
            st == SFetch || st == SMemRead || st == SMemWrite,
            st == SMemWrite,
            st == SFetch && rdy,
            st == SMemWb || st == SAluWb};
  endfunction

  task automatic add_step(input int st, input bit halted);
    step_t s;
    if (halted) return;
    s.st  = st;
    s.rdy = 1'($urandom_range(0, 1));
    seq.push_back(s);
  endtask

  // A memory phase waiting w cycles; Timeout or more stalled cycles end in HALT
  task automatic add_wait(input int st, input int w, inout bit halted);
    step_t s;
    if (halted) return;
    s.st  = st;
    s.rdy = 1'b0;
    if (w >= Timeout) begin
      for (int k = 0; k < Timeout; k++) seq.push_back(s);
      halted = 1'b1;
    end else begin
      for (int k = 0; k < w; k++) seq.push_back(s);
      s.rdy = 1'b1;
      seq.push_back(s);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check_eq("rst_state", bus.state_o, SFetch);
    check_eq("rst_illegal", bus.illegal, 0);
    check_eq("rst_bus_err", bus.bus_err, 0);
    check_eq("rst_strobes", strobes_now(), 0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_strobes", strobes_now(), 0);
    rst = 1'b1;
  endtask

  // Runs one instruction from FETCH; called mid-cycle with the DUT in FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zero, input int fw, input int mw, input int hold);
    bit halted = 1'b0;
    bit ill    = 1'b0;
    bit berr   = 1'b0;
    int exp_rw;
    int rw_seen = 0;
    step_t s;
    seq.delete();
    add_wait(SFetch, fw, halted);
    berr = halted;
    if (!halted) begin
      add_step(SDecode, halted);
      if (!is_legal(op, f3)) begin
        ill    = 1'b1;
        halted = 1'b1;
      end else begin
        case (op)
          OpLw: begin
            add_step(SMemAdr, halted);
            add_wait(SMemRead, mw, halted);
            berr = halted;
            add_step(SMemWb, halted);
          end
          OpSw: begin
            add_step(SMemAdr, halted);
            add_wait(SMemWrite, mw, halted);
            berr = halted;
          end
          OpR:  begin add_step(SExecR, halted); add_step(SAluWb, halted); end
          OpI:  begin add_step(SExecI, halted); add_step(SAluWb, halted); end
          OpBr: add_step(SBranch, halted);
          default: begin add_step(SJal, halted); add_step(SAluWb, halted); end
        endcase
      end
    end
    exp_rw = (!halted && (op == OpLw || op == OpR || op == OpI || op == OpJal)) ? 1 : 0;
    if (halted) begin
      for (int k = 0; k < hold; k++) begin
        s.st  = SHalt;
        s.rdy = 1'($urandom_range(0, 1));
        seq.push_back(s);
      end
    end
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.Zero     = zero;
    foreach (seq[k]) begin
      bus.mem_ready = seq[k].rdy;
      #1;
      check_eq("state", bus.state_o, seq[k].st);
      check_eq("strobes", strobes_now(), exp_strobes(seq[k].st, seq[k].rdy, f3, zero));
      check_eq("result_src", bus.ResultSrc,
               seq[k].st == SMemWb ? 1 : (seq[k].st == SFetch && seq[k].rdy) ? 2 : 0);
      check_eq("alu_control", bus.ALUControl,
               (seq[k].st == SExecR || seq[k].st == SExecI) ? alu_code(op, f3, f7) :
               seq[k].st == SBranch ? 1 : 0);
      check_eq("illegal", bus.illegal, seq[k].st == SHalt ? ill : 1'b0);
      check_eq("bus_err", bus.bus_err, seq[k].st == SHalt ? berr : 1'b0);
      if (bus.RegWrite) rw_seen++;
      @(posedge clk);
      #1;
    end
    check_eq("regwrite_pulses", rw_seen, exp_rw);
    if (halted) begin
      do_reset();
    end else begin
      check_eq("back_to_fetch", bus.state_o, SFetch);
    end
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 24) == 0) return Timeout + $urandom_range(0, 3);
    return $urandom_range(0, 4);
  endfunction

  initial begin
    logic [6:0] op;
    bus.op        = '0;
    bus.funct3    = '0;
    bus.funct7_5  = 1'b0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset();

    // sub, lw with three-cycle read stall, branch polarity, illegal hold
    run_instr(OpR, 3'd0, 1'b1, 1'b0, 0, 0, 0);
    run_instr(OpLw, 3'd2, 1'b0, 1'b0, 0, 3, 0);
    run_instr(OpBr, 3'd0, 1'b0, 1'b1, 0, 0, 0);
    run_instr(OpBr, 3'd0, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OpBr, 3'd1, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OpJal, 3'd0, 1'b0, 1'b0, 1, 0, 0);
    run_instr(OpI, 3'd0, 1'b1, 1'b0, 0, 0, 0);
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 20);
    // Watchdog: 16 stalled fetch cycles halt; ready on the 16th cycle wins
    run_instr(OpR, 3'd7, 1'b0, 1'b0, Timeout, 0, 3);
    run_instr(OpR, 3'd6, 1'b0, 1'b0, Timeout - 1, 0, 0);
    run_instr(OpSw, 3'd2, 1'b0, 1'b0, 0, Timeout, 3);

    // Reset during a stalled store drops MemWrite immediately
    bus.op        = OpSw;
    bus.funct3    = 3'd2;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      #1;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    #1;
    check_eq("sw_state", bus.state_o, SMemWrite);
    check_eq("sw_memwrite", bus.MemWrite, 1);
    rst = 1'b0;
    #1;
    check_eq("abort_memwrite", bus.MemWrite, 0);
    check_eq("abort_memreq", bus.MemReq, 0);
    check_eq("abort_state", bus.state_o, SFetch);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("release_state", bus.state_o, SFetch);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: op = OpLw;
        1: op = OpSw;
        2: op = OpR;
        3: op = OpI;
        4: op = OpBr;
        5: op = OpJal;
        default: begin
          do op = 7'($urandom);
          while (op inside {OpLw, OpSw, OpR, OpI, OpBr, OpJal});
        end
      endcase
      run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), rand_wait(), rand_wait(), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
